bcd_countdown: RTL and testbench
================================

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 Parameter PRESCALE, default 1, meaning clock cycles per decrement; legal range 1..65535.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load  input  1  captures din_tens/din_ones into count registers (IDLE only).
REQ-005 din_tens  input  4  BCD tens digit to load.
REQ-006 din_ones  input  4  BCD ones digit to load.
REQ-007 start  input  1  begins countdown from the loaded value (IDLE only).
REQ-008 pause  input  1  level; holds count and prescaler while high in RUN.
REQ-009 tens  output  4  current tens digit, registered.
REQ-010 ones  output  4  current ones digit, registered.
REQ-011 bout  output  1  borrow pulse, one cycle, on ones 0->9 wrap.
REQ-012 busy  output  1  high in RUN or PAUSE.
REQ-013 done  output  1  one-cycle pulse when count reaches 00.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, with state registered.
REQ-015 In IDLE with load=1, the block SHALL capture the digits next edge; any digit >9 SHALL be clamped to 9.
REQ-016 In IDLE with load=1 and start=1 on the same cycle, load SHALL win and start SHALL be ignored.
REQ-017 In IDLE with start=1, load=0 and count!=00, the FSM SHALL go to RUN next edge with prescaler cleared to 0.
REQ-018 In IDLE with start=1 and count==00, the FSM SHALL go to DONE next edge with no decrement.
REQ-019 In RUN with pause=0, the prescaler SHALL increment each cycle; when it equals PRESCALE-1 it SHALL wrap to 0 and a decrement tick SHALL occur that edge.
REQ-020 For PRESCALE=1, a tick SHALL occur every RUN cycle: first decrement on the edge after entering RUN, so count changes 1 cycle after the start edge.
REQ-021 On a tick with ones!=0, ones SHALL decrement by 1 and tens SHALL hold.
REQ-022 On a tick with ones==0 and tens!=0, ones SHALL become 9, tens SHALL decrement by 1, and bout SHALL be 1 for exactly the cycle in which the new digits are visible.
REQ-023 On a tick that yields 00, the FSM SHALL go to DONE on that same edge; no borrow below 00 and no wrap to 99 SHALL ever occur.
REQ-024 In RUN with pause=1, the FSM SHALL go to PAUSE; prescaler and digits SHALL hold and no tick SHALL occur that cycle.
REQ-025 In PAUSE, the FSM SHALL stay while pause=1 and return to RUN when pause=0, with the prescaler value preserved.
REQ-026 In DONE, done SHALL be 1 for exactly one cycle, digits SHALL read 00, and the FSM SHALL go to IDLE next edge.
REQ-027 load and start SHALL be ignored outside IDLE; pause SHALL be ignored outside RUN/PAUSE.
REQ-028 busy SHALL be 1 exactly in RUN and PAUSE; done, bout and busy SHALL all be registered and glitch-free.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL set state=IDLE, tens=0, ones=0, prescaler=0, bout=0, busy=0 and done=0, overriding all other inputs.
REQ-030 Reset asserted mid-RUN or mid-PAUSE SHALL abort the countdown with no done pulse.
REQ-031 After reset deasserts, the block SHALL accept load on the first following cycle.

Verification
REQ-032 PRESCALE=1, load 12, start -> sequence 11,10,09(bout=1),08..01,00 with done high in the 00 cycle; busy high for 12 cycles; done never repeats.
REQ-033 PRESCALE=4, load 03, start -> each digit held 4 cycles; done 12 cycles after the RUN entry edge.
REQ-034 Load tens=4'hC, ones=4'hF -> tens=9, ones=9; then load 00 and start -> done next cycle, busy never high, no bout.
REQ-035 PRESCALE=3, load 05, start, pause for 5 cycles mid-prescale -> digits and prescaler frozen; total run cycles = 15 + 5.
REQ-036 load 20, start, rst at count 15 -> next cycle 00, IDLE, busy=0, done=0; load/start in RUN during the run are ignored.

Source files
------------

// File: rtl/bcd_countdown.sv
// Two-digit BCD down-counter with load, start, pause and a programmable
// prescaler; busy/bout/done are registered single-clock outputs.
module bcd_countdown #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] din_tens,
  input  logic [3:0] din_ones,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       bout,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] PreMax = 16'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  tens_q, tens_d, ones_q, ones_d;
  logic [15:0] presc_q, presc_d;
  logic        bout_q, bout_d, busy_q, busy_d, done_q, done_d;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    presc_d = presc_q;
    bout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          tens_d = clamp9(din_tens);
          ones_d = clamp9(din_ones);
        end else if (start) begin
          presc_d = '0;
          state_d = (tens_q == 4'd0 && ones_q == 4'd0) ? StDone : StRun;
        end
      end
      StRun, StPause: begin
        if (pause) begin
          state_d = StPause;
        end else begin
          // Leaving PAUSE counts as a normal run cycle from the held prescaler.
          state_d = StRun;
          if (presc_q == PreMax) begin
            presc_d = '0;
            if (ones_q != 4'd0) begin
              ones_d = ones_q - 4'd1;
            end else if (tens_q != 4'd0) begin
              ones_d = 4'd9;
              tens_d = tens_q - 4'd1;
              bout_d = 1'b1;
            end
            if (tens_d == 4'd0 && ones_d == 4'd0) state_d = StDone;
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun) || (state_d == StPause);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tens_q  <= '0;
      ones_q  <= '0;
      presc_q <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      presc_q <= presc_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown: three instances (PRESCALE 1, 4, 3) share stimulus.
module tb_bcd_countdown;

  logic       clk = 1'b0;
  logic       rst, load, start, pause;
  logic [3:0] din_tens, din_ones;

  logic [3:0] tens_a, ones_a, tens_b, ones_b, tens_c, ones_c;
  logic       bout_a, busy_a, done_a, bout_b, busy_b, done_b, bout_c, busy_c, done_c;
  logic [10:0] va, vb, vc;

  int npass = 0;
  int ntotal = 0;
  int busy_cnt;
  logic done_seen;

  always #5 clk = ~clk;

  bcd_countdown #(.PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .din_tens(din_tens), .din_ones(din_ones),
    .start(start), .pause(pause), .tens(tens_a), .ones(ones_a), .bout(bout_a),
    .busy(busy_a), .done(done_a)
  );
  bcd_countdown #(.PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .load(load), .din_tens(din_tens), .din_ones(din_ones),
    .start(start), .pause(pause), .tens(tens_b), .ones(ones_b), .bout(bout_b),
    .busy(busy_b), .done(done_b)
  );
  bcd_countdown #(.PRESCALE(3)) dut_c (
    .clk(clk), .rst(rst), .load(load), .din_tens(din_tens), .din_ones(din_ones),
    .start(start), .pause(pause), .tens(tens_c), .ones(ones_c), .bout(bout_c),
    .busy(busy_c), .done(done_c)
  );

  assign va = {tens_a, ones_a, bout_a, busy_a, done_a};
  assign vb = {tens_b, ones_b, bout_b, busy_b, done_b};
  assign vc = {tens_c, ones_c, bout_c, busy_c, done_c};

  // {tens, ones, bout, busy, done}
  function automatic logic [10:0] ev(input int t, input int o, input bit b, input bit bu,
                                     input bit d);
    return {4'(t), 4'(o), b, bu, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
    din_tens = 4'd0; din_ones = 4'd0;
    step();
    rst = 1'b0;
  endtask

  task automatic do_load(input int t, input int o);
    load = 1'b1; din_tens = 4'(t); din_ones = 4'(o);
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #2;
    // Reset state
    do_reset();
    chk("reset_a", 32'(va), 32'(ev(0, 0, 0, 0, 0)));
    chk("reset_b", 32'(vb), 32'(ev(0, 0, 0, 0, 0)));

    // PRESCALE=1, 12 down to 00
    do_load(1, 2);
    chk("load12", 32'(va), 32'(ev(1, 2, 0, 0, 0)));
    do_start();
    chk("run12", 32'(va), 32'(ev(1, 2, 0, 1, 0)));
    for (int k = 11; k >= 1; k--) begin
      step();
      chk($sformatf("p1_cnt%0d", k), 32'(va), 32'(ev(k / 10, k % 10, k == 9, 1, 0)));
    end
    step();
    chk("p1_done", 32'(va), 32'(ev(0, 0, 0, 0, 1)));
    step();
    chk("p1_done_once", 32'(va), 32'(ev(0, 0, 0, 0, 0)));

    // PRESCALE=4, 03: each digit held 4 cycles, done 12 cycles after RUN entry
    do_reset();
    do_load(0, 3);
    do_start();
    chk("p4_entry", 32'(vb), 32'(ev(0, 3, 0, 1, 0)));
    for (int n = 1; n <= 12; n++) begin
      step();
      chk($sformatf("p4_cyc%0d", n), 32'(vb), 32'(ev(0, 3 - n / 4, 0, n < 12, n == 12)));
    end

    // PRESCALE=3, 05 with a 5-cycle pause mid-prescale
    do_reset();
    do_load(0, 5);
    do_start();
    busy_cnt = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 60 && !done_seen; i++) begin
      if (busy_c) busy_cnt++;
      pause = (i >= 4 && i < 9);
      step();
      if (i >= 4 && i < 9)
        chk($sformatf("p3_pause%0d", i), 32'(vc), 32'(ev(0, 4, 0, 1, 0)));
      done_seen = done_c;
    end
    pause = 1'b0;
    chk("p3_done_seen", 32'(done_seen), 32'd1);
    chk("p3_busy_cycles", 32'(busy_cnt), 32'd20);

    // Clamp, load-beats-start, start at 00
    do_reset();
    do_load(12, 15);
    chk("clamp99", 32'(va), 32'(ev(9, 9, 0, 0, 0)));
    load = 1'b1; start = 1'b1; din_tens = 4'd1; din_ones = 4'd2;
    step();
    load = 1'b0; start = 1'b0;
    chk("load_wins", 32'(va), 32'(ev(1, 2, 0, 0, 0)));
    step();
    chk("load_wins_idle", 32'(va), 32'(ev(1, 2, 0, 0, 0)));
    do_load(0, 0);
    do_start();
    chk("zero_start_done", 32'(va), 32'(ev(0, 0, 0, 0, 1)));
    step();
    chk("zero_start_idle", 32'(va), 32'(ev(0, 0, 0, 0, 0)));

    // Reset mid-run; load/start ignored while running
    do_reset();
    do_load(2, 0);
    do_start();
    for (int n = 1; n <= 5; n++) begin
      if (n == 2 || n == 3) begin
        load = 1'b1; start = 1'b1; din_tens = 4'd7; din_ones = 4'd7;
      end else begin
        load = 1'b0; start = 1'b0;
      end
      step();
      chk($sformatf("r_cnt%0d", 20 - n), 32'(va),
          32'(ev((20 - n) / 10, (20 - n) % 10, n == 1, 1, 0)));
    end
    load = 1'b0; start = 1'b0;
    rst = 1'b1;
    step();
    chk("mid_reset", 32'(va), 32'(ev(0, 0, 0, 0, 0)));
    rst = 1'b0; load = 1'b1; din_tens = 4'd3; din_ones = 4'd4;
    step();
    load = 1'b0;
    chk("load_after_reset", 32'(va), 32'(ev(3, 4, 0, 0, 0)));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
